xy_route_stage: RTL and testbench

Registered, flow-controlled route-compute stage for the mesh router input path, generalising the combinational dimension-order outport decoder. It accepts flits over a valid/ready handshake and computes a one-hot output port from the signed difference between the head flit's destination and the router's own coordinates. It locks that port for the whole wormhole packet and presents each flit one cycle later to the switch allocator.

---
 rtl/xy_route_stage.sv | 209 ++++++++++++++++++++
 tb/tb_xy_route_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_route_stage.sv
// Registered XY (dimension-order) route-compute stage with wormhole route lock and valid/ready flow control.
// Optional destination bounds check and DROP state enabled by defining ROUTE_BOUNDS_CHECK_EN.
module xy_route_stage #(
    parameter int COORD_W    = 30,
    parameter int PAYLOAD_W  = 32,
    parameter int MESH_X_MAX = 15,
    parameter int MESH_Y_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   cur_x,
    input  logic [COORD_W-1:0]   cur_y,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_head,
    input  logic                 in_tail,
    input  logic [COORD_W-1:0]   in_dest_x,
    input  logic [COORD_W-1:0]   in_dest_y,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_port,
    output logic                 out_head,
    output logic                 out_tail,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 busy,
    output logic                 err_proto,
    output logic                 err_oob
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [4:0] PORT_LOCAL_C = 5'b00001;
    localparam logic [4:0] PORT_EAST_C  = 5'b00010;
    localparam logic [4:0] PORT_WEST_C  = 5'b00100;
    localparam logic [4:0] PORT_NORTH_C = 5'b01000;
    localparam logic [4:0] PORT_SOUTH_C = 5'b10000;

    localparam logic [COORD_W:0]   DIFF_ZERO_C = {(COORD_W+1){1'b0}};
    localparam logic [COORD_W-1:0] X_MAX_C     = COORD_W'(MESH_X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C     = COORD_W'(MESH_Y_MAX);

`ifdef ROUTE_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN_C = 1'b1;
`else
    localparam logic BOUNDS_EN_C = 1'b0;
`endif

    // Differences are taken one bit wider than the coordinates so that they can never overflow.
    function automatic logic [4:0] route_f(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] here_x,
        input logic [COORD_W-1:0] here_y
    );
        logic [COORD_W:0] dx;
        logic [COORD_W:0] dy;
        logic [4:0]       port;
        dx = {dest_x[COORD_W-1], dest_x} - {here_x[COORD_W-1], here_x};
        dy = {dest_y[COORD_W-1], dest_y} - {here_y[COORD_W-1], here_y};
        if (dx[COORD_W]) begin
            port = PORT_WEST_C;
        end else if (dx != DIFF_ZERO_C) begin
            port = PORT_EAST_C;
        end else if (dy[COORD_W]) begin
            port = PORT_SOUTH_C;
        end else if (dy != DIFF_ZERO_C) begin
            port = PORT_NORTH_C;
        end else begin
            port = PORT_LOCAL_C;
        end
        return port;
    endfunction

    // True when a signed coordinate lies outside [0, lim].
    function automatic logic oob_f(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lim
    );
        return v[COORD_W-1] || (v > lim);
    endfunction

    state_t                 state_r;
    state_t                 state_n;
    logic [4:0]             route_r;
    logic [4:0]             route_n;
    logic                   out_valid_r;
    logic [4:0]             out_port_r;
    logic                   out_head_r;
    logic                   out_tail_r;
    logic [PAYLOAD_W-1:0]   out_payload_r;
    logic                   busy_r;
    logic                   err_proto_r;
    logic                   err_oob_r;

    logic                   in_ready_s;
    logic                   xfer_s;
    logic [4:0]             head_route_s;
    logic                   dest_oob_s;
    logic                   load_s;
    logic [4:0]             load_port_s;
    logic                   load_head_s;
    logic                   err_proto_s;
    logic                   err_oob_s;

    assign in_ready_s   = (state_r == ST_DROP) ? 1'b1 : (!out_valid_r || out_ready);
    assign xfer_s       = in_valid && in_ready_s;
    assign head_route_s = route_f(in_dest_x, in_dest_y, cur_x, cur_y);
    assign dest_oob_s   = oob_f(in_dest_x, X_MAX_C) || oob_f(in_dest_y, Y_MAX_C);

    // Next-state, route-lock and output-load decisions.
    always_comb begin
        state_n     = state_r;
        route_n     = route_r;
        load_s      = 1'b0;
        load_port_s = route_r;
        load_head_s = 1'b0;
        err_proto_s = 1'b0;
        err_oob_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!xfer_s) begin
                    state_n = ST_IDLE;
                end else if (!in_head) begin
                    err_proto_s = 1'b1;
                end else if (BOUNDS_EN_C && dest_oob_s) begin
                    err_oob_s = 1'b1;
                    state_n   = in_tail ? ST_IDLE : ST_DROP;
                end else begin
                    load_s      = 1'b1;
                    load_port_s = head_route_s;
                    load_head_s = 1'b1;
                    route_n     = head_route_s;
                    state_n     = in_tail ? ST_IDLE : ST_PKT;
                end
            end
            ST_PKT: begin
                if (xfer_s) begin
                    // A stray head is demoted to a body flit on the locked port.
                    load_s      = 1'b1;
                    err_proto_s = in_head;
                    state_n     = in_tail ? ST_IDLE : ST_PKT;
                end else begin
                    state_n = ST_PKT;
                end
            end
`ifdef ROUTE_BOUNDS_CHECK_EN
            ST_DROP: begin
                if (xfer_s && in_tail) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DROP;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, route lock, output flit register and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            route_r       <= 5'b00000;
            out_valid_r   <= 1'b0;
            out_port_r    <= 5'b00000;
            out_head_r    <= 1'b0;
            out_tail_r    <= 1'b0;
            out_payload_r <= {PAYLOAD_W{1'b0}};
            busy_r        <= 1'b0;
            err_proto_r   <= 1'b0;
            err_oob_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            route_r     <= route_n;
            busy_r      <= (state_n != ST_IDLE);
            err_proto_r <= err_proto_s;
            err_oob_r   <= err_oob_s;
            if (load_s) begin
                out_valid_r   <= 1'b1;
                out_port_r    <= load_port_s;
                out_head_r    <= load_head_s;
                out_tail_r    <= in_tail;
                out_payload_r <= in_payload;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_port    = out_port_r;
    assign out_head    = out_head_r;
    assign out_tail    = out_tail_r;
    assign out_payload = out_payload_r;
    assign busy        = busy_r;
    assign err_proto   = err_proto_r;
    assign err_oob     = err_oob_r;

endmodule

// File: tb/tb_xy_route_stage.sv
// Directed, table-driven bench for xy_route_stage: routing table, route lock, backpressure,
// protocol errors, reset mid-packet and (with ROUTE_BOUNDS_CHECK_EN) the bounds check.
module tb_xy_route_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] cur_x = 30'd0;
    logic [29:0] cur_y = 30'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_head = 1'b0;
    logic        in_tail = 1'b0;
    logic [29:0] in_dest_x = 30'd0;
    logic [29:0] in_dest_y = 30'd0;
    logic [31:0] in_payload = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_port;
    logic        out_head;
    logic        out_tail;
    logic [31:0] out_payload;
    logic        busy;
    logic        err_proto;
    logic        err_oob;

    int checks = 0;
    int failures = 0;

`ifdef ROUTE_BOUNDS_CHECK_EN
    localparam bit BOUNDS_TB = 1'b1;
`else
    localparam bit BOUNDS_TB = 1'b0;
`endif

    localparam logic [4:0] P_L = 5'b00001;
    localparam logic [4:0] P_E = 5'b00010;
    localparam logic [4:0] P_W = 5'b00100;
    localparam logic [4:0] P_N = 5'b01000;
    localparam logic [4:0] P_S = 5'b10000;

    typedef struct {
        logic [29:0] cx;
        logic [29:0] cy;
        logic [29:0] dx;
        logic [29:0] dy;
        logic [4:0]  port;
        bit          oob;
    } vec_t;

    vec_t vecs[9];

    xy_route_stage dut (
        .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_head(in_head), .in_tail(in_tail),
        .in_dest_x(in_dest_x), .in_dest_y(in_dest_y), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
        .out_head(out_head), .out_tail(out_tail), .out_payload(out_payload),
        .busy(busy), .err_proto(err_proto), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic head, input logic tail, input logic [29:0] dx,
                         input logic [29:0] dy, input logic [31:0] pl);
        in_valid   = 1'b1;
        in_head    = head;
        in_tail    = tail;
        in_dest_x  = dx;
        in_dest_y  = dy;
        in_payload = pl;
    endtask

    initial begin
        vecs[0] = '{30'd3, 30'd3, 30'd5, 30'd1, P_E, 1'b0};
        vecs[1] = '{30'd3, 30'd3, 30'd3, 30'd7, P_N, 1'b0};
        vecs[2] = '{30'd3, 30'd3, 30'd3, 30'd3, P_L, 1'b0};
        vecs[3] = '{30'd3, 30'd3, 30'h3FFFFFFE, 30'd9, P_W, 1'b1};
        vecs[4] = '{30'd3, 30'd3, 30'd3, 30'd0, P_S, 1'b0};
        vecs[5] = '{30'h1FFFFFFF, 30'd0, 30'h20000000, 30'd0, P_W, 1'b1};
        vecs[6] = '{30'h20000000, 30'd0, 30'h1FFFFFFF, 30'd0, P_E, 1'b1};
        vecs[7] = '{30'd0, 30'h1FFFFFFF, 30'd0, 30'h20000000, P_S, 1'b1};
        vecs[8] = '{30'd5, 30'd5, 30'd5, 30'd6, P_N, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_port", out_port, 5'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_proto", err_proto, 1'b0);
        chk("rst_err_oob", err_oob, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Single-flit routing table
        for (int i = 0; i < 9; i++) begin
            cur_x = vecs[i].cx;
            cur_y = vecs[i].cy;
            drive(1'b1, 1'b1, vecs[i].dx, vecs[i].dy, 32'hA000_0000 + i);
            tick();
            in_valid = 1'b0;
            if (BOUNDS_TB && vecs[i].oob) begin
                chk($sformatf("vec%0d_dropped", i), out_valid, 1'b0);
                chk($sformatf("vec%0d_err_oob", i), err_oob, 1'b1);
            end else begin
                chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
                chk($sformatf("vec%0d_port", i), out_port, vecs[i].port);
                chk($sformatf("vec%0d_head", i), out_head, 1'b1);
                chk($sformatf("vec%0d_tail", i), out_tail, 1'b1);
                chk($sformatf("vec%0d_payload", i), out_payload, 32'hA000_0000 + i);
                chk($sformatf("vec%0d_busy", i), busy, 1'b0);
            end
            tick();
            chk($sformatf("vec%0d_drained", i), out_valid, 1'b0);
        end

        // Route lock over a 4-flit packet; cur/dest changes on body flits must be ignored
        cur_x = 30'd3;
        cur_y = 30'd3;
        drive(1'b1, 1'b0, 30'd3, 30'd0, 32'h100);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("lock%0d_valid", k), out_valid, 1'b1);
            chk($sformatf("lock%0d_port", k), out_port, P_S);
            chk($sformatf("lock%0d_payload", k), out_payload, 32'h100 + k);
            chk($sformatf("lock%0d_head", k), out_head, (k == 0));
            chk($sformatf("lock%0d_tail", k), out_tail, (k == 3));
            chk($sformatf("lock%0d_busy", k), busy, (k < 3));
            drive(1'b0, (k == 2), 30'd7, 30'd7, 32'h101 + k);
            cur_x = 30'd0;
            cur_y = 30'd9;
            if (k == 3) in_valid = 1'b0;
        end
        tick();
        chk("lock_end_valid", out_valid, 1'b0);
        chk("lock_end_busy", busy, 1'b0);

        // Backpressure: three stalled cycles mid-packet
        cur_x = 30'd3;
        cur_y = 30'd3;
        drive(1'b1, 1'b0, 30'd5, 30'd1, 32'h200);
        tick();
        chk("bp_head_port", out_port, P_E);
        chk("bp_head_payload", out_payload, 32'h200);
        drive(1'b0, 1'b0, 30'd0, 30'd0, 32'h201);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("bp_stall%0d_valid", s), out_valid, 1'b1);
            chk($sformatf("bp_stall%0d_payload", s), out_payload, 32'h200);
            chk($sformatf("bp_stall%0d_port", s), out_port, P_E);
            chk($sformatf("bp_stall%0d_head", s), out_head, 1'b1);
            chk($sformatf("bp_stall%0d_in_ready", s), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_body_payload", out_payload, 32'h201);
        chk("bp_body_head", out_head, 1'b0);
        chk("bp_body_port", out_port, P_E);
        drive(1'b0, 1'b1, 30'd0, 30'd0, 32'h202);
        tick();
        chk("bp_tail_payload", out_payload, 32'h202);
        chk("bp_tail_tail", out_tail, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("bp_end_valid", out_valid, 1'b0);
        chk("bp_end_busy", busy, 1'b0);

        // Body flit in IDLE
        drive(1'b0, 1'b1, 30'd0, 30'd0, 32'h300);
        tick();
        chk("perr_idle_no_out", out_valid, 1'b0);
        chk("perr_idle_pulse", err_proto, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("perr_idle_pulse_end", err_proto, 1'b0);

        // Head inside an open packet
        drive(1'b1, 1'b0, 30'd3, 30'd7, 32'h310);
        tick();
        chk("perr_pkt_head_port", out_port, P_N);
        drive(1'b1, 1'b0, 30'd5, 30'd1, 32'h311);
        tick();
        chk("perr_pkt_fwd_valid", out_valid, 1'b1);
        chk("perr_pkt_fwd_head", out_head, 1'b0);
        chk("perr_pkt_fwd_port", out_port, P_N);
        chk("perr_pkt_fwd_payload", out_payload, 32'h311);
        chk("perr_pkt_pulse", err_proto, 1'b1);
        drive(1'b0, 1'b1, 30'd0, 30'd0, 32'h312);
        tick();
        chk("perr_pkt_pulse_end", err_proto, 1'b0);
        chk("perr_pkt_tail_port", out_port, P_N);
        chk("perr_pkt_tail", out_tail, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("perr_pkt_end_busy", busy, 1'b0);

        // Asynchronous reset after flit 2 of 4
        drive(1'b1, 1'b0, 30'd3, 30'd0, 32'h400);
        tick();
        drive(1'b0, 1'b0, 30'd0, 30'd0, 32'h401);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_port", out_port, 5'b0);
        chk("mrst_head", out_head, 1'b0);
        chk("mrst_tail", out_tail, 1'b0);
        chk("mrst_payload", out_payload, 32'h0);
        chk("mrst_busy", busy, 1'b0);
        #2;
        rst = 1'b0;
        drive(1'b1, 1'b1, 30'd0, 30'd3, 32'h410);
        tick();
        chk("mrst_next_valid", out_valid, 1'b1);
        chk("mrst_next_port", out_port, P_W);
        chk("mrst_next_head", out_head, 1'b1);
        chk("mrst_next_err", err_proto, 1'b0);
        in_valid = 1'b0;
        tick();

`ifdef ROUTE_BOUNDS_CHECK_EN
        // Out-of-bounds head plus two body flits are dropped
        drive(1'b1, 1'b0, 30'd16, 30'd2, 32'h500);
        #1;
        chk("oob_in_ready_head", in_ready, 1'b1);
        tick();
        chk("oob_head_no_out", out_valid, 1'b0);
        chk("oob_pulse", err_oob, 1'b1);
        chk("oob_busy", busy, 1'b1);
        drive(1'b0, 1'b0, 30'd0, 30'd0, 32'h501);
        out_ready = 1'b0;
        #1;
        chk("oob_in_ready_body", in_ready, 1'b1);
        tick();
        chk("oob_body_no_out", out_valid, 1'b0);
        chk("oob_pulse_end", err_oob, 1'b0);
        drive(1'b0, 1'b1, 30'd0, 30'd0, 32'h502);
        #1;
        chk("oob_in_ready_tail", in_ready, 1'b1);
        tick();
        chk("oob_tail_no_out", out_valid, 1'b0);
        chk("oob_tail_busy", busy, 1'b0);
        chk("oob_tail_no_pulse", err_oob, 1'b0);
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 30'd3, 30'd16, 32'h510);
        tick();
        chk("oob_y_no_out", out_valid, 1'b0);
        chk("oob_y_pulse", err_oob, 1'b1);
        chk("oob_y_busy", busy, 1'b0);
        drive(1'b1, 1'b1, 30'd15, 30'd15, 32'h520);
        tick();
        chk("oob_edge_valid", out_valid, 1'b1);
        chk("oob_edge_port", out_port, P_E);
        chk("oob_edge_no_pulse", err_oob, 1'b0);
`else
        // Without the check, any destination is routed and err_oob stays low
        drive(1'b1, 1'b1, 30'd16, 30'd2, 32'h500);
        tick();
        chk("nochk_valid", out_valid, 1'b1);
        chk("nochk_port", out_port, P_E);
        chk("nochk_err_oob", err_oob, 1'b0);
`endif
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
